md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 37 +++
 rtl/md_unit_if.sv | 13 +
 rtl/md_unit.sv | 110 +++++++++++
 tb/tb_md_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings and defaults for the multiply/divide unit and the decode logic
// that drives its operation code.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_S_IDLE,
    MD_S_RUN
  } md_state_e;

  // Returns {remainder, quotient}; the one overflowing case is pinned explicitly.
  function automatic logic [63:0] md_sdiv(input logic signed [31:0] n,
                                          input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Execute-stage request/response bundle between the pipeline and md_unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers; the result is
// computed at issue and held in a pending register until the busy window ends.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;

  logic signed [31:0] a_s, b_s;
  logic signed [63:0] a_ext, b_ext;
  logic [63:0]        res;

  assign a_s   = md.a;
  assign b_s   = md.b;
  assign a_ext = a_s;
  assign b_ext = b_s;

  // Result layout is {hi, lo}: product halves, or {remainder, quotient}.
  always_comb begin
    res = '0;
    case (md.op)
      MD_MULT:  res = a_ext * b_ext;
      MD_MULTU: res = {32'd0, md.a} * {32'd0, md.b};
      MD_DIV:   if (md.b != 32'd0) res = md_sdiv(a_s, b_s);
      MD_DIVU:  if (md.b != 32'd0) res = {md.a % md.b, md.a / md.b};
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      MD_S_IDLE: begin
        if (md.start) begin
          case (md.op)
            MD_MULT, MD_MULTU: begin
              pend_d  = res;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MD_S_RUN;
              busy_d  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              // A zero divisor commits the current HI/LO back onto themselves.
              pend_d  = (md.b == 32'd0) ? {hi_q, lo_q} : res;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = MD_S_RUN;
              busy_d  = 1'b1;
            end
            MD_MTHI: hi_d = md.a;
            MD_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      MD_S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          busy_d  = 1'b0;
          state_d = MD_S_IDLE;
        end
      end
      default: state_d = MD_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO/latency per request go into a
// scoreboard queue at issue and are compared when the busy window closes.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;

  logic clk;
  logic reset;
  md_unit_if mdif();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one request at the current negedge and follows its busy window.
  // inj > 0 drives an mthi 0xABCD during that busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int ncyc, input int inj);
    sb_t         e;
    int          seen;
    int          guard;
    logic [31:0] hi_before;
    hi_before = mdif.hi;
    mdif.start = 1'b1;
    mdif.op    = o;
    mdif.a     = ia;
    mdif.b     = ib;
    sb_q.push_back('{tag, ncyc, ehi, elo});
    @(negedge clk);
    mdif.start = 1'b0;
    seen  = 0;
    guard = 0;
    while (mdif.busy === 1'b1 && guard < 40) begin
      seen++;
      guard++;
      if (seen == inj) begin
        mdif.start = 1'b1;
        mdif.op    = MD_MTHI;
        mdif.a     = 32'h0000_ABCD;
      end
      @(negedge clk);
      if (mdif.start) begin
        mdif.start = 1'b0;
        chk({tag, "_ignored_mthi"}, 64'(mdif.hi), 64'(hi_before));
      end
    end
    e = sb_q.pop_front();
    chk({e.tag, "_busy_cycles"}, 64'(seen), 64'(e.cyc));
    chk({e.tag, "_busy_low"}, 64'(mdif.busy), 64'd0);
    chk({e.tag, "_hi"}, 64'(mdif.hi), 64'(e.hi));
    chk({e.tag, "_lo"}, 64'(mdif.lo), 64'(e.lo));
  endtask

  initial begin
    int late;
    reset      = 1'b0;
    mdif.start = 1'b0;
    mdif.op    = MD_NONE;
    mdif.a     = '0;
    mdif.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(mdif.busy), 64'd0);
    chk("reset_hi", 64'(mdif.hi), 64'd0);
    chk("reset_lo", 64'(mdif.lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd4,        32'hFFFF_FFFF, 32'hFFFF_FFF4, 5, 0);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5, 0);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_op("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 0);
    run_op("divu_big",  MD_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 10, 0);
    run_op("mthi",      MD_MTHI,  32'h0000_0011, 32'd0,        32'h0000_0011, 32'h0FFF_FFFF, 0, 0);
    run_op("mtlo",      MD_MTLO,  32'h0000_0022, 32'd0,        32'h0000_0011, 32'h0000_0022, 0, 0);
    run_op("divu_zero", MD_DIVU,  32'd7,         32'd0,        32'h0000_0011, 32'h0000_0022, 10, 0);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 0);
    run_op("multu_inj", MD_MULTU, 32'd2,         32'd3,        32'h0000_0000, 32'h0000_0006, 5, 3);
    run_op("b2b_1",     MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5, 0);
    run_op("b2b_2",     MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5, 0);
    run_op("rsvd",      MD_RSVD,  32'h1234_5678, 32'd9,        32'h4000_0000, 32'h0000_0000, 0, 0);
    run_op("mtlo_55",   MD_MTLO,  32'h0000_0055, 32'd0,        32'h4000_0000, 32'h0000_0055, 0, 0);

    // Abort a divide in its fourth busy cycle with an asynchronous reset.
    mdif.start = 1'b1;
    mdif.op    = MD_DIV;
    mdif.a     = 32'd100;
    mdif.b     = 32'd7;
    @(negedge clk);
    mdif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 64'(mdif.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(mdif.busy), 64'd0);
    chk("abort_hi", 64'(mdif.hi), 64'd0);
    chk("abort_lo", 64'(mdif.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    late = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (mdif.busy !== 1'b0 || mdif.hi !== 32'd0 || mdif.lo !== 32'd0) late++;
    end
    chk("abort_no_late_commit", 64'(late), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
